// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file: FSM state encodings
// and the address-width helper used to derive the AW default from DEPTH.
package reg_file_mp_pkg;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: packed read ports, write port, debug port,
// status flags and the exposed FSM state.
interface reg_file_mp_if #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int NUM_RD = 2
);

  // Write handshake: wr_en is a one-cycle request, accepted only while ready=1;
  // any request made while ready=0 (or aimed at a hardwired-zero register) is
  // discarded and acknowledged one cycle later by a single-cycle wr_drop pulse.
  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD*DW-1:0] rd_data;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [DW-1:0]        wr_data;
  logic [AW-1:0]        dbg_addr;
  logic [DW-1:0]        dbg_val;
  logic                 ready;
  logic                 wr_drop;
  logic [0:0]           dbg_state;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, dbg_addr,
    input  rd_data, dbg_val, ready, wr_drop, dbg_state
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, dbg_addr,
    output rd_data, dbg_val, ready, wr_drop, dbg_state
  );

endinterface

// File: rtl/reg_file_mp_bypass_mux.sv
// Per-read-port output select: masks reads during clear, forces the zero
// register, and forwards same-cycle write data when bypass is enabled.
module reg_file_bypass_mux #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [DW-1:0] mem_data_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          ready_i,
  output logic [DW-1:0] rd_data_o
);

  // Zero-register test comes before bypass so a dropped write to r0 never forwards.
  always_comb begin
    rd_data_o = mem_data_i;
    if (!ready_i) begin
      rd_data_o = '0;
    end else if (ZERO_REG != 0 && rd_addr_i == '0) begin
      rd_data_o = '0;
    end else if (BYPASS != 0 && wr_en_i && rd_addr_i == wr_addr_i) begin
      rd_data_o = wr_data_i;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-read-port register file with a post-reset clear engine,
// optional hardwired-zero register, optional write bypass and a debug port.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic          clk,
  input logic          startin_n,
  reg_file_mp_if.slave bus
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic          ready_q, ready_d;
  logic          wr_drop_q, wr_drop_d;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          zero_hit;

  assign zero_hit = (ZERO_REG != 0) && (bus.wr_addr == '0);

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ready_d   = ready_q;
    wr_drop_d = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = bus.wr_addr;
    mem_wdata = bus.wr_data;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        wr_drop_d = bus.wr_en;
        // Terminal test on DEPTH-1 rather than on the pointer wrapping to 0.
        if (clr_ptr_q == AW'(DEPTH - 1)) begin
          state_d = ST_READY;
          ready_d = 1'b1;
        end
      end
      default: begin
        wr_drop_d = bus.wr_en && zero_hit;
        mem_we    = bus.wr_en && !zero_hit;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!startin_n) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Storage has no reset of its own; contents are only zeroed by the clear engine.
  always_ff @(posedge clk) begin
    if (startin_n && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    reg_file_bypass_mux #(
      .DW       (DW),
      .AW       (AW),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_mux (
      .mem_data_i (mem_q[bus.rd_addr[i*AW +: AW]]),
      .rd_addr_i  (bus.rd_addr[i*AW +: AW]),
      .wr_en_i    (bus.wr_en),
      .wr_addr_i  (bus.wr_addr),
      .wr_data_i  (bus.wr_data),
      .ready_i    (ready_q),
      .rd_data_o  (bus.rd_data[i*DW +: DW])
    );
  end

  always_comb begin
    bus.dbg_val = mem_q[bus.dbg_addr];
    if (!ready_q || (ZERO_REG != 0 && bus.dbg_addr == '0)) begin
      bus.dbg_val = '0;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.wr_drop   = wr_drop_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two instances (4-port bypass/zero-reg, 2-port plain)
// driven in lockstep against a reference model feeding an expected queue.
module tb_reg_file_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic startin_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] ra [4];
  logic          wr_en;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [AW-1:0] da;

  reg_file_mp_if #(.DW(DW), .AW(AW), .NUM_RD(4)) bus_a ();
  reg_file_mp_if #(.DW(DW), .AW(AW), .NUM_RD(2)) bus_b ();

  assign bus_a.rd_addr  = {ra[3], ra[2], ra[1], ra[0]};
  assign bus_a.wr_en    = wr_en;
  assign bus_a.wr_addr  = wa;
  assign bus_a.wr_data  = wd;
  assign bus_a.dbg_addr = da;
  assign bus_b.rd_addr  = {ra[1], ra[0]};
  assign bus_b.wr_en    = wr_en;
  assign bus_b.wr_addr  = wa;
  assign bus_b.wr_data  = wd;
  assign bus_b.dbg_addr = da;

  reg_file_mp #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .startin_n(startin_n), .bus(bus_a)
  );
  reg_file_mp #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .startin_n(startin_n), .bus(bus_b)
  );

  // Reference model state: A has zero-reg and bypass, B has neither.
  logic [DW-1:0] ma_mem [DEPTH];
  logic [DW-1:0] mb_mem [DEPTH];
  logic          m_ready = 1'b0;
  int            m_cnt = 0;
  logic          ma_drop = 1'b0;
  logic          mb_drop = 1'b0;
  logic          last_ready;

  logic [DW-1:0] exp_q [$];
  int n_checks = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input bit is_a, input logic [AW-1:0] a);
    if (!m_ready) return '0;
    if (is_a && a == '0) return '0;
    if (is_a && wr_en && a == wa) return wd;
    return is_a ? ma_mem[a] : mb_mem[a];
  endfunction

  function automatic logic [DW-1:0] exp_dbg(input bit is_a);
    if (!m_ready) return '0;
    if (is_a && da == '0) return '0;
    return is_a ? ma_mem[da] : mb_mem[da];
  endfunction

  // One clock: push expectations, compare at negedge, advance model at posedge.
  task automatic cycle();
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_rd(1'b1, ra[i]));
    for (int i = 0; i < 2; i++) exp_q.push_back(exp_rd(1'b0, ra[i]));
    exp_q.push_back(exp_dbg(1'b1));
    exp_q.push_back(exp_dbg(1'b0));
    exp_q.push_back({31'd0, m_ready});
    exp_q.push_back({31'd0, ma_drop});
    exp_q.push_back({31'd0, mb_drop});
    exp_q.push_back({31'd0, m_ready});
    @(negedge clk);
    last_ready = bus_a.ready;
    for (int i = 0; i < 4; i++) check_val($sformatf("a_rd%0d", i), bus_a.rd_data[i*DW +: DW], exp_q.pop_front());
    for (int i = 0; i < 2; i++) check_val($sformatf("b_rd%0d", i), bus_b.rd_data[i*DW +: DW], exp_q.pop_front());
    check_val("a_dbg", bus_a.dbg_val, exp_q.pop_front());
    check_val("b_dbg", bus_b.dbg_val, exp_q.pop_front());
    check_val("a_ready", {31'd0, bus_a.ready}, exp_q.pop_front());
    check_val("a_drop", {31'd0, bus_a.wr_drop}, exp_q.pop_front());
    check_val("b_drop", {31'd0, bus_b.wr_drop}, exp_q.pop_front());
    check_val("b_state", {31'd0, bus_b.dbg_state}, exp_q.pop_front());
    @(posedge clk);
    if (!startin_n) begin
      m_ready = 1'b0; m_cnt = 0; ma_drop = 1'b0; mb_drop = 1'b0;
    end else if (!m_ready) begin
      ma_mem[m_cnt] = '0;
      mb_mem[m_cnt] = '0;
      ma_drop = wr_en;
      mb_drop = wr_en;
      if (m_cnt == DEPTH - 1) m_ready = 1'b1;
      m_cnt++;
    end else begin
      ma_drop = wr_en && (wa == '0);
      mb_drop = 1'b0;
      if (wr_en && wa != '0) ma_mem[wa] = wd;
      if (wr_en) mb_mem[wa] = wd;
    end
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wa = '0; wd = '0; da = '0;
    for (int i = 0; i < 4; i++) ra[i] = '0;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wa = a; wd = d;
  endtask

  task automatic count_clear(input string tag);
    int lows;
    lows = 0;
    for (int k = 0; k < 40; k++) begin
      da = AW'(k);
      cycle();
      if (!last_ready) lows++;
    end
    check_val(tag, lows, 32);
  endtask

  task automatic dbg_sweep();
    wr_en = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      da = AW'(k);
      ra[0] = AW'(k);
      ra[1] = AW'(DEPTH - 1 - k);
      cycle();
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ma_mem[i] = '0;
      mb_mem[i] = '0;
    end
    idle();
    startin_n = 1'b0;
    cycle();
    cycle();
    startin_n = 1'b1;
    count_clear("clear_len");

    // Fill with all-ones, then reset: the clear must wipe every entry.
    for (int k = 0; k < DEPTH; k++) begin
      write(AW'(k), 32'hFFFF_FFFF);
      ra[0] = AW'(k);
      cycle();
    end
    idle();
    dbg_sweep();
    startin_n = 1'b0;
    cycle();
    startin_n = 1'b1;
    count_clear("reclear_len");
    dbg_sweep();

    // Same-cycle read of a written address: A forwards, B returns old value.
    idle();
    ra[0] = 5'd1; da = 5'd1;
    write(5'd1, 32'hAAAA_AAAA);
    cycle();
    wr_en = 1'b0;
    cycle();
    cycle();

    // Write to register 0: dropped on A, stored on B.
    ra[0] = 5'd0; ra[1] = 5'd0; da = 5'd0;
    write(5'd0, 32'h5555_5555);
    cycle();
    wr_en = 1'b0;
    cycle();
    cycle();

    // Write during clear is dropped and never lands.
    idle();
    startin_n = 1'b0;
    cycle();
    startin_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k == 5) write(5'd2, 32'h1234_5678);
      else wr_en = 1'b0;
      ra[0] = 5'd2; da = 5'd2;
      cycle();
    end

    // Reset mid-clear restarts the full clear.
    idle();
    startin_n = 1'b0;
    cycle();
    startin_n = 1'b1;
    for (int k = 0; k < 10; k++) cycle();
    startin_n = 1'b0;
    cycle();
    startin_n = 1'b1;
    count_clear("restart_len");

    // All read ports on the write address at once.
    for (int i = 0; i < 4; i++) ra[i] = 5'd3;
    da = 5'd3;
    write(5'd3, 32'hDEAD_BEEF);
    cycle();
    wr_en = 1'b0;
    cycle();

    // Random traffic with a bias towards read/write address collisions.
    for (int k = 0; k < 200; k++) begin
      wr_en = 1'($urandom_range(0, 1));
      wa = AW'($urandom_range(0, DEPTH - 1));
      wd = $urandom();
      da = AW'($urandom_range(0, DEPTH - 1));
      for (int i = 0; i < 4; i++) begin
        ra[i] = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      end
      cycle();
    end
    idle();
    dbg_sweep();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
